// File: rtl/bit_morph_filter.sv
// -----------------------------------------------------------------------------
// bit_morph_filter
//
// Streaming binary morphology on a 1-bit image. A KSIZE x KSIZE window is
// assembled internally from KSIZE-1 line buffers and the current pixel; the
// per-frame operation is bypass, erosion, dilation or morphological gradient
// with a square or cross structuring element.
//
// The window is anchored at the incoming pixel (rows row-(KSIZE-1)..row,
// columns col-(KSIZE-1)..col), so the filtered image is the centred result
// shifted down/right by R = (KSIZE-1)/2. Bypass applies no shift.
//
// Ports:
//   clk               pixel clock
//   rst_n             asynchronous active-low reset
//   per_frame_vsync   input frame valid
//   per_frame_href    input line valid, one pixel per clk while high
//   per_img_Bit       input pixel (1 = object)
//   cfg_mode          00 bypass, 01 erode, 10 dilate, 11 gradient
//   cfg_cross         0 square element, 1 cross element
//   post_frame_vsync  per_frame_vsync delayed 3 clk
//   post_frame_href   per_frame_href delayed 3 clk
//   post_img_Bit      processed pixel, 0 whenever post_frame_href is 0
// -----------------------------------------------------------------------------
module bit_morph_filter #(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter int          KSIZE     = 3      // 3 or 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_img_Bit,
    input  logic [1:0] cfg_mode,
    input  logic       cfg_cross,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_img_Bit
);
    localparam int R   = (KSIZE - 1) / 2;
    localparam int NLB = KSIZE - 1;
    localparam int AW  = (int'(IMG_HDISP) > 1) ? $clog2(int'(IMG_HDISP)) : 1;

    // ---------------- framing, counters, config latch ----------------
    logic        vsync_prev, href_prev;
    logic        vs_rise, href_fall;
    logic [10:0] col, col_next, row, row_eff;
    logic [1:0]  mode_latch, mode_eff;
    logic        cross_latch, cross_eff;
    logic [2:0]  vsync_dly, href_dly;

    assign vs_rise   = per_frame_vsync & ~vsync_prev;
    assign href_fall = href_prev & ~per_frame_href;

    // A pixel arriving in the same clk as the vsync edge already belongs to
    // the new frame, so it sees row 0 and the freshly sampled config.
    assign row_eff   = vs_rise ? 11'd0 : row;
    assign mode_eff  = vs_rise ? cfg_mode : mode_latch;
    assign cross_eff = vs_rise ? cfg_cross : cross_latch;

    always_comb begin
        col_next = 11'd0;
        if (per_frame_href)
            col_next = (col == IMG_HDISP) ? col : col + 11'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev  <= 1'b0;
            href_prev   <= 1'b0;
            col         <= 11'd0;
            row         <= 11'd0;
            mode_latch  <= 2'b00;
            cross_latch <= 1'b0;
            vsync_dly   <= 3'b000;
            href_dly    <= 3'b000;
        end else begin
            vsync_prev <= per_frame_vsync;
            href_prev  <= per_frame_href;
            col        <= col_next;
            if (vs_rise) begin
                row         <= 11'd0;
                mode_latch  <= cfg_mode;
                cross_latch <= cfg_cross;
            end else if (href_fall && row != IMG_VDISP - 11'd1) begin
                row <= row + 11'd1;
            end
            vsync_dly <= {vsync_dly[1:0], per_frame_vsync};
            href_dly  <= {href_dly[1:0], per_frame_href};
        end
    end

    // ---------------- line buffers ----------------
    // The read is registered, so the address is the column the *next* pixel
    // will occupy; its data is then ready in the same clk as that pixel.
    logic [AW-1:0]    rd_addr, wr_addr;
    logic             wr_en;
    logic [NLB-1:0]   lb_rd;
    logic [KSIZE-1:0] tap;   // tap[k] = pixel from row-k at the current column

    assign rd_addr = (col_next < IMG_HDISP) ? col_next[AW-1:0] : '0;
    assign wr_addr = col[AW-1:0];
    assign wr_en   = per_frame_href && (col < IMG_HDISP);
    assign tap[0]  = per_img_Bit;

    genvar gi;
    generate
        for (gi = 0; gi < NLB; gi++) begin : g_lb
            logic mem [0:int'(IMG_HDISP)-1];
            logic rd_q;
            // Buffer gi takes the tap one row newer, forming a row cascade.
            always_ff @(posedge clk) begin
                if (wr_en)
                    mem[wr_addr] <= tap[gi];
                rd_q <= mem[rd_addr];
            end
            assign lb_rd[gi]  = rd_q;
            assign tap[gi+1]  = rd_q;
        end
    endgenerate

    // ---------------- S0: window shift ----------------
    // win_reg[r][c] = pixel at (row-r, col-c) of the pixel held in S0.
    logic [KSIZE-1:0] win_reg [0:KSIZE-1];
    logic [10:0]      row_s0, col_s0;
    logic             inr_s0, cross_s0;
    logic [1:0]       mode_s0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KSIZE; r++)
                win_reg[r] <= '0;
            row_s0   <= 11'd0;
            col_s0   <= 11'd0;
            inr_s0   <= 1'b0;
            cross_s0 <= 1'b0;
            mode_s0  <= 2'b00;
        end else begin
            if (per_frame_href) begin
                for (int r = 0; r < KSIZE; r++)
                    win_reg[r] <= {win_reg[r][KSIZE-2:0], tap[r]};
            end
            row_s0   <= row_eff;
            col_s0   <= col;
            inr_s0   <= (col < IMG_HDISP);
            cross_s0 <= cross_eff;
            mode_s0  <= mode_eff;
        end
    end

    // ---------------- S1: per-row reductions ----------------
    // Taps above/left of the frame or outside the cross contribute the
    // identity value, which is the same as leaving them out of the reduction.
    logic [KSIZE-1:0] and_row, or_row;

    always_comb begin
        and_row = '1;
        or_row  = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                if ((row_s0 >= 11'(r)) && (col_s0 >= 11'(c)) &&
                    (!cross_s0 || r == R || c == R)) begin
                    and_row[r] = and_row[r] & win_reg[r][c];
                    or_row[r]  = or_row[r] | win_reg[r][c];
                end
            end
        end
    end

    logic [KSIZE-1:0] and_s1, or_s1;
    logic             pix_s1, inr_s1;
    logic [1:0]       mode_s1;
    logic             ero, dil, res;

    // ---------------- S2: column reduction and mode select ----------------
    assign ero = &and_s1;
    assign dil = |or_s1;

    always_comb begin
        case (mode_s1)
            2'b00:   res = pix_s1;
            2'b01:   res = ero;
            2'b10:   res = dil;
            default: res = dil & ~ero;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_s1       <= '0;
            or_s1        <= '0;
            pix_s1       <= 1'b0;
            inr_s1       <= 1'b0;
            mode_s1      <= 2'b00;
            post_img_Bit <= 1'b0;
        end else begin
            and_s1       <= and_row;
            or_s1        <= or_row;
            pix_s1       <= win_reg[0][0];
            inr_s1       <= inr_s0;
            mode_s1      <= mode_s0;
            post_img_Bit <= href_dly[1] & inr_s1 & res;
        end
    end

    assign post_frame_vsync = vsync_dly[2];
    assign post_frame_href  = href_dly[2];

endmodule
